// File: rtl/font_rom_arbiter.sv
// Font ROM arbiter: shares one synchronous font ROM between NUM_REQ text renderers.
// Each cycle it grants one requester, drives the ROM address, and steers the returned
// row byte back to the owner as a one-cycle rsp_valid strobe, ROM_LAT+1 clocks after gnt.
// Optional build macro FONT_ARB_FIXED_PRIO_EN: when defined, the lowest eligible index
// always wins (requester 0 has priority). When undefined, a round-robin pointer is used.
module font_rom_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned STAGES = ROM_LAT + 1;

    logic [NUM_REQ-1:0] eligible;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;

    // Owner pipeline: stage 0 is loaded together with gnt, last stage drives rsp_valid
    logic [STAGES-1:0]  pipe_vld;
    logic [IDX_W-1:0]   pipe_idx [STAGES];

`ifndef FONT_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]   last;
`endif

    // Winner selection; a requester granted this cycle is masked so a held req is never double-granted
    always_comb begin
        int unsigned cand;
        cand      = 0;
        eligible  = req & ~gnt;
        win_found = 1'b0;
        win_idx   = '0;
`ifdef FONT_ARB_FIXED_PRIO_EN
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = i;
            if (!win_found && eligible[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
`else
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = (32'(last) + i) % NUM_REQ;
            if (!win_found && eligible[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
`endif
    end

    // Grant, ROM address and round-robin pointer registers; address holds when idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt      <= '0;
            rom_addr <= '0;
`ifndef FONT_ARB_FIXED_PRIO_EN
            last     <= IDX_W'(NUM_REQ - 1);
`endif
        end else if (win_found) begin
            gnt      <= NUM_REQ'(1) << win_idx;
            rom_addr <= req_addr[32'(win_idx) * ADDR_W +: ADDR_W];
`ifndef FONT_ARB_FIXED_PRIO_EN
            last     <= win_idx;
`endif
        end else begin
            gnt      <= '0;
        end
    end

    // Owner pipeline tracks {valid, index} of each read until its ROM data is due
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                pipe_idx[k] <= '0;
            end
        end else begin
            pipe_vld    <= {pipe_vld[STAGES-2:0], win_found};
            pipe_idx[0] <= win_idx;
            for (int unsigned k = 1; k < STAGES; k++) begin
                pipe_idx[k] <= pipe_idx[k-1];
            end
        end
    end

    // Response register: capture ROM row and strobe the owning requester
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else if (pipe_vld[STAGES-1]) begin
            rsp_valid <= NUM_REQ'(1) << pipe_idx[STAGES-1];
            rsp_data  <= rom_data;
        end else begin
            rsp_valid <= '0;
        end
    end

endmodule
